// File: rtl/if_fetch_unit.sv
// RV32 fetch unit: one outstanding imem request, single-entry decode buffer, redirect squash.
// Request-to-decode latency 2 cycles (zero-wait memory); stalls in HOLD while decode is not ready.
module if_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic            if_valid_q, if_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          // A response arriving with the redirect is already stale; otherwise it is still in flight.
          state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          if_instr_d = imem_rsp_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + XLEN'(4);
          state_d    = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        // Redirect takes priority: a decode handshake in the same cycle is void.
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_d       = redirect_pc;
          state_d    = ST_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ) & ~redirect_valid & ~rst;
  assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with variable latency, fetch-stream scoreboard.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk            = 1'b0;
  logic        rst            = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        if_valid;
  logic        if_ready       = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within 20 cycles", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory and reference-model state, owned by the monitor (negedge).
  bit          pending, nxt_rsp, stale;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          mem_delay = 0;      // <0: random latency
  bit          exp_req_now, exp_ifv_now;
  logic [31:0] exp_q[$];           // PC of the next instruction decode must see
  bit          prev_hold;
  logic [31:0] prev_pc, prev_instr;
  int          acc_cnt = 0;
  int          dlv_cnt = 0;

  always @(negedge clk) begin : monitor
    bit          dlv, busy, rn, ifn;
    logic [31:0] e;
    if (rst) begin
      chk("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      pending     = 1'b0;
      stale       = 1'b0;
      nxt_rsp     = 1'b0;
      exp_req_now = 1'b1;
      exp_ifv_now = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      busy = pending;
      dlv  = if_valid && if_ready && !redirect_valid;
      e    = exp_q[0];
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req_now && !redirect_valid});
      chk("if_valid", {31'd0, if_valid}, {31'd0, exp_ifv_now});
      if (imem_req_valid) chk("req_addr", imem_req_addr, {e[31:2], 2'b00});
      if (prev_hold) begin
        chk("hold_pc", if_pc, prev_pc);
        chk("hold_instr", if_instr, prev_instr);
      end
      if (dlv) begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, mem_word({e[31:2], 2'b00}));
        exp_q.push_back(e + 32'd4);
        dlv_cnt++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end
      // Expected fetch behaviour for the next cycle, from protocol events.
      if (redirect_valid)   rn = !(busy && !imem_rsp_valid);
      else if (exp_req_now) rn = !imem_req_ready;
      else                  rn = (imem_rsp_valid && stale) || dlv;
      ifn = !redirect_valid && ((if_valid && !if_ready) || (imem_rsp_valid && busy && !stale));
      if (redirect_valid && busy && !imem_rsp_valid) stale = 1'b1;
      else if (imem_rsp_valid)                       stale = 1'b0;
      exp_req_now = rn;
      exp_ifv_now = ifn;
      prev_hold   = if_valid && !if_ready && !redirect_valid;
      prev_pc     = if_pc;
      prev_instr  = if_instr;
      // Memory responder.
      if (imem_rsp_valid) pending = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        pending   = 1'b1;
        pend_addr = imem_req_addr;
        pend_wait = (mem_delay < 0) ? int'($urandom_range(0, 2)) : mem_delay;
        acc_cnt++;
      end
      nxt_rsp = 1'b0;
      if (pending) begin
        if (pend_wait == 0) nxt_rsp = 1'b1;
        else pend_wait--;
      end
    end
  end

  task automatic tick(input bit r, input bit rv, input logic [31:0] rpc, input bit ir, input bit rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = ir;
    imem_req_ready = rdy;
    imem_rsp_valid = nxt_rsp;
    imem_rsp_data  = nxt_rsp ? mem_word(pend_addr) : $urandom;
  endtask

  task automatic go(input int n, input bit ir);
    repeat (n) tick(1'b0, 1'b0, 32'd0, ir, 1'b1);
  endtask

  task automatic redir(input logic [31:0] a);
    tick(1'b0, 1'b1, a, 1'b1, 1'b1);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic until_accept();
    int start;
    start = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      go(1, 1'b1);
      sample();
      if (acc_cnt != start) return;
    end
    timeout("accept");
  endtask

  task automatic until_valid();
    for (int i = 0; i < 20; i++) begin
      go(1, 1'b0);
      sample();
      if (if_valid) return;
    end
    timeout("if_valid");
  endtask

  initial begin
    int          d0;
    logic [31:0] rpc;
    repeat (3) tick(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    sample();
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);

    // Zero-wait streaming: one instruction every 3 cycles.
    mem_delay = 0;
    d0 = dlv_cnt;
    go(9, 1'b1);
    sample();
    chk("stream_count", dlv_cnt - d0, 32'd3);

    // Decode stall for 5 cycles.
    until_valid();
    go(5, 1'b0);
    sample();
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    go(4, 1'b1);

    // Redirect in WAIT, response 2 cycles later -> DROP.
    mem_delay = 2;
    until_accept();
    redir(32'h100);
    mem_delay = 0;
    go(3, 1'b1);
    sample();
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_req_addr", imem_req_addr, 32'h100);
    go(4, 1'b1);

    // Redirect coincident with the response.
    until_accept();
    redir(32'h200);
    go(1, 1'b1);
    sample();
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    chk("coinc_if_valid", {31'd0, if_valid}, 32'd0);
    go(5, 1'b1);

    // Redirect in HOLD.
    until_valid();
    redir(32'h40);
    go(1, 1'b1);
    sample();
    chk("holdredir_if_valid", {31'd0, if_valid}, 32'd0);
    chk("holdredir_req_addr", imem_req_addr, 32'h40);
    go(6, 1'b1);

    // Unaligned redirect target.
    redir(32'h103);
    go(1, 1'b1);
    sample();
    chk("unaligned_req_addr", imem_req_addr, 32'h100);
    go(6, 1'b1);

    // PC wrap.
    redir(32'hFFFF_FFFC);
    go(1, 1'b1);
    sample();
    chk("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
    go(3, 1'b1);
    sample();
    chk("wrap_next_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // Reset while waiting on memory.
    mem_delay = 2;
    until_accept();
    tick(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    mem_delay = 0;
    go(1, 1'b1);
    sample();
    chk("midrst_req_addr", imem_req_addr, RESET_PC);
    chk("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    go(6, 1'b1);

    // Randomized traffic against the scoreboard.
    mem_delay = -1;
    d0 = dlv_cnt;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 4)
        0:       rpc = $urandom & 32'h0000_0FFC;
        1:       rpc = $urandom;
        2:       rpc = 32'hFFFF_FFF8 + (($urandom % 2) * 4);
        default: rpc = $urandom & 32'h0000_3FFC;
      endcase
      tick(($urandom % 100) == 0, ($urandom % 100) < 10, rpc,
           ($urandom % 10) < 7, ($urandom % 4) != 0);
    end
    go(1, 1'b1);
    sample();
    chk("random_progress", {31'd0, (dlv_cnt - d0) > 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch unit for the RV32 core. It holds the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready interface, and buffers the returned word for decode with a valid/ready handshake. It consumes the execute stage's redirect outputs (branch_taken / branch_target) to steer the PC and discard wrong-path fetches.

## Interface
- RESET_PC, default 32'h0000_0000: first fetch address after reset.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  execute-stage branch_taken; PC redirect request.
- redirect_pc  in  `XLEN  execute-stage branch_target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  `XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid, one pulse per accepted request.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts instruction.
- if_pc  out  `XLEN  PC of buffered instruction.
- if_instr  out  32  buffered instruction.

## Operation
- Registers: pc, state, if_valid, if_pc, if_instr.
- States: REQ (request pc), WAIT (request accepted, awaiting response), DROP (wrong-path response outstanding), HOLD (instruction buffered).
- imem_req_valid = (state==REQ) & ~redirect_valid & ~rst. imem_req_addr = {pc[31:2],2'b00}. Redirect bits [1:0] are dropped.
- REQ: redirect_valid -> pc<=redirect_pc, stay REQ, no request issued. Else imem_req_ready -> WAIT, pc unchanged.
- WAIT: redirect_valid -> pc<=redirect_pc. If imem_rsp_valid in the same cycle, discard response -> REQ. Otherwise -> DROP. Else imem_rsp_valid -> if_instr<=imem_rsp_data, if_pc<=pc, if_valid<=1, pc<=pc+4 -> HOLD.
- DROP: redirect_valid -> pc<=redirect_pc (latest wins). imem_rsp_valid -> discard -> REQ. Else stay.
- HOLD: redirect_valid -> if_valid<=0, pc<=redirect_pc -> REQ. Else if_ready -> if_valid<=0 -> REQ. Else hold; if_pc/if_instr stable.
- A decode handshake in the same cycle as redirect_valid is void. Decode flushes on the same signal.
- imem_rsp_valid in REQ or HOLD is ignored.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Instruction memory shares rst and drops any in-flight request on reset. rst in any state -> REQ, pending response forgotten.

## Timing
- Reset values (after any edge with rst=1): state=REQ, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0. imem_req_valid=0 while rst=1.
- First request is driven in the first cycle with rst=0.
- With zero-wait memory (ready=1, rsp one cycle after accept) and if_ready=1: request at cycle N, rsp at N+1, if_valid=1 at N+2, next request at N+3. Throughput is 1 instruction per 3 cycles.
- Redirect latency: the new address is presented in REQ the cycle after redirect_valid (from REQ, WAIT+rsp, or HOLD). From DROP, it is presented the cycle after the stale response.
- At most one outstanding request at all times.
- imem_req_addr and imem_req_valid stay stable while the request waits on imem_req_ready=0 (absent redirect).

## Test plan
- Reset, RESET_PC=0, zero-wait memory, if_ready=1 -> requests at 0x0, 0x4, 0x8 every 3 cycles. if_valid with if_pc 0x0/0x4/0x8 two cycles after each request. Nothing is driven while rst=1.
- HOLD with if_ready=0 for 5 cycles -> if_valid=1, and if_pc/if_instr are held constant. No imem request. Request at pc+4 the cycle after if_ready=1.
- Redirect 0x100 in WAIT, response arrives 2 cycles later -> DROP, stale word never reaches if_valid. Next request addr 0x100. if_pc=0x100.
- Redirect 0x200 coincident with imem_rsp_valid in WAIT -> response discarded. Request 0x200 the next cycle.
- Redirect 0x40 in HOLD with if_ready=1 -> if_valid=0 next cycle, next request 0x40, old pc+4 never requested. Redirect 0x103 -> request addr 0x100.
- Redirect 0xFFFF_FFFC -> fetch at 0xFFFF_FFFC, next request 0x0. rst asserted mid-WAIT -> next request at RESET_PC, if_valid=0.
